// File: rtl/fp_sub32_seq.sv
// Multi-cycle fp32 subtractor D = A - B: iterative align, add, one-bit normalize.
// Define FPSUB32_BARREL_ALIGN_EN to align in one cycle with a barrel shifter.
module fp_sub32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] D,
  output logic [2:0]  flags
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPEC, S_ALIGN, S_ADD, S_NORM
  } state_t;

  state_t      state_q, state_d;
  logic        ph_q, ph_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [7:0]  ea_q, ea_d, eb_q, eb_d;
  logic [24:0] ma_q, ma_d, mb_q, mb_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  flg_q, flg_d;

  logic        in_spec;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0] spec_res;
  logic [2:0]  spec_flg;
  logic [7:0]  d_ab, d_ba;

  assign in_spec = (A[30:23] == 8'h00) || (A[30:23] == 8'hFF)
                || (B[30:23] == 8'h00) || (B[30:23] == 8'hFF);

  assign a_nan  = (ea_q == 8'hFF) && (ma_q[22:0] != 23'd0);
  assign b_nan  = (eb_q == 8'hFF) && (mb_q[22:0] != 23'd0);
  assign a_inf  = (ea_q == 8'hFF) && (ma_q[22:0] == 23'd0);
  assign b_inf  = (eb_q == 8'hFF) && (mb_q[22:0] == 23'd0);
  assign a_zero = (ea_q == 8'h00);
  assign b_zero = (eb_q == 8'h00);
  assign d_ab   = ea_q - eb_q;
  assign d_ba   = eb_q - ea_q;

  // sb_q already carries the inverted sign of B, so -B is {sb_q, B}
  always_comb begin
    spec_res = {sa_q, ea_q, ma_q[22:0]};
    spec_flg = 3'b000;
    if (a_nan || b_nan) begin
      spec_res = 32'h7FC00000;
      spec_flg = 3'b100;
    end else if (a_inf && b_inf && (sa_q != sb_q)) begin
      spec_res = 32'h7FC00000;
      spec_flg = 3'b100;
    end else if (a_inf) begin
      spec_res = {sa_q, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_res = {sb_q, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      spec_res = {sa_q & sb_q, 31'd0};
    end else if (a_zero) begin
      spec_res = {sb_q, eb_q, mb_q[22:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = A[31];
          sb_d    = ~B[31];
          ea_d    = A[30:23];
          eb_d    = B[30:23];
          ma_d    = {2'b01, A[22:0]};
          mb_d    = {2'b01, B[22:0]};
          ph_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = in_spec ? S_SPEC : S_ALIGN;
        end
      end
      S_SPEC: begin
        // two-cycle bypass so special results share a fixed latency of 2
        ph_d = 1'b1;
        if (ph_q) begin
          res_d   = spec_res;
          flg_d   = spec_flg;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ALIGN: begin
`ifdef FPSUB32_BARREL_ALIGN_EN
        if (ea_q > eb_q) begin
          mb_d = (d_ab > 8'd24) ? 25'd0 : (mb_q >> d_ab);
          eb_d = ea_q;
        end else if (eb_q > ea_q) begin
          ma_d = (d_ba > 8'd24) ? 25'd0 : (ma_q >> d_ba);
          ea_d = eb_q;
        end
        state_d = S_ADD;
`else
        if (ea_q == eb_q) begin
          state_d = S_ADD;
        end else if (ea_q > eb_q) begin
          mb_d = (d_ab > 8'd24) ? 25'd0 : (mb_q >> 1);
          eb_d = (d_ab > 8'd24) ? ea_q : eb_q + 8'd1;
        end else begin
          ma_d = (d_ba > 8'd24) ? 25'd0 : (ma_q >> 1);
          ea_d = (d_ba > 8'd24) ? eb_q : ea_q + 8'd1;
        end
`endif
      end
      S_ADD: begin
        if (sa_q == sb_q) begin
          ma_d = ma_q + mb_q;
        end else if (ma_q >= mb_q) begin
          ma_d = ma_q - mb_q;
        end else begin
          ma_d = mb_q - ma_q;
          sa_d = sb_q;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (ma_q == 25'd0) begin
          res_d   = 32'h0;
          flg_d   = 3'b000;
          done_d  = 1'b1;
        end else if (ma_q[24]) begin
          ma_d = ma_q >> 1;
          ea_d = ea_q + 8'd1;
          if (ea_q == 8'd254) begin
            res_d  = {sa_q, 8'hFF, 23'd0};
            flg_d  = 3'b010;
            done_d = 1'b1;
          end
        end else if (!ma_q[23]) begin
          ma_d = ma_q << 1;
          ea_d = ea_q - 8'd1;
          if (ea_q == 8'd1) begin
            res_d  = {sa_q, 31'd0};
            flg_d  = 3'b001;
            done_d = 1'b1;
          end
        end else begin
          res_d  = {sa_q, ea_q, ma_q[22:0]};
          flg_d  = 3'b000;
          done_d = 1'b1;
        end
        if (done_d) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ea_q    <= 8'd0;
      eb_q    <= 8'd0;
      ma_q    <= 25'd0;
      mb_q    <= 25'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 32'h0;
      flg_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign D     = res_q;
  assign flags = flg_q;

endmodule

// File: tb/tb_fp_sub32_seq.sv
// Scoreboard bench for fp_sub32_seq: results and latency checked per accept.
// Honors FPSUB32_BARREL_ALIGN_EN for expected main-path latency.
module tb_fp_sub32_seq;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [31:0] A, B, D;
  logic [2:0]  flags;

  fp_sub32_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [2:0]  f;
    int          lat;
    int          deff;
  } vec_t;

  exp_t        sbq[$];
  exp_t        e;
  vec_t        tv[18];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, n_acc = 0, n_done = 0, nd;
  logic [31:0] cur_d;
  logic [2:0]  cur_f;
  int          cur_lat;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      n_acc -= sbq.size();
      sbq.delete();
    end else if (start && !busy) begin
      sbq.push_back('{cur_d, cur_f, cur_lat, cyc});
      n_acc++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (done) begin
      n_done++;
      if (sbq.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("D", D, e.d);
        check("flags", {29'b0, flags}, {29'b0, e.f});
        if (e.lat >= 0)
          check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic set_exp(input vec_t v);
    A     = v.a;
    B     = v.b;
    cur_d = v.d;
    cur_f = v.f;
`ifdef FPSUB32_BARREL_ALIGN_EN
    cur_lat = (v.lat < 0) ? v.lat : v.lat - v.deff;
`else
    cur_lat = v.lat;
`endif
  endtask

  task automatic run(input vec_t v);
    wait_idle();
    set_exp(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    tv = '{
      '{32'h40400000, 32'h3F800000, 32'h40000000, 3'b000,  4,  1},
      '{32'h3F800000, 32'hBF800000, 32'h40000000, 3'b000,  4,  0},
      '{32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 3'b000, 27,  1},
      '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100,  2,  0},
      '{32'h40A00000, 32'h40A00000, 32'h00000000, 3'b000, -1,  0},
      '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b010, -1,  0},
      '{32'h00800000, 32'h00C00000, 32'h80000000, 3'b001, -1,  0},
      '{32'h4C000000, 32'h3F800000, 32'h4C000000, 3'b000,  4,  1},
      '{32'h4B800000, 32'h3F800000, 32'h4B800000, 3'b000, 27, 24},
      '{32'hC0400000, 32'hBF800000, 32'hC0000000, 3'b000,  4,  1},
      '{32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000,  2,  0},
      '{32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000,  2,  0},
      '{32'h80000000, 32'h00000000, 32'h80000000, 3'b000,  2,  0},
      '{32'h00000000, 32'h80000000, 32'h00000000, 3'b000,  2,  0},
      '{32'h00000001, 32'h40000000, 32'hC0000000, 3'b000,  2,  0},
      '{32'h40000000, 32'h00000005, 32'h40000000, 3'b000,  2,  0},
      '{32'h7FC00001, 32'h00000000, 32'h7FC00000, 3'b100,  2,  0},
      '{32'hFF800000, 32'hFF800000, 32'h7FC00000, 3'b100,  2,  0}
    };
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    cur_d = '0; cur_f = '0; cur_lat = -1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_D", D, 32'h0);
    check("rst_flags", {29'b0, flags}, 32'd0);
    rst = 1'b0;

    foreach (tv[i]) run(tv[i]);

    // start held high across whole operations
    wait_idle();
    set_exp(tv[0]);
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;

    // reset while aligning a d=21 operation
    wait_idle();
    A = 32'h4A000000; B = 32'h3F800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_D", D, 32'h0);
    check("abort_flags", {29'b0, flags}, 32'd0);
    rst = 1'b0;
    nd = n_done;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", n_done, nd);

    run(tv[9]);
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    check("drain", sbq.size(), 32'd0);
    check("done_vs_accept", n_done, n_acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
